sreg_readout_rx: RTL and testbench

Downstream readout controller and deserializer for the 2-lane pixel shift register.
- Sequences `shift` (load/shift phases) for the register and captures its registered 2-bit output.
- Reassembles each 42-bit pixel word and hands it downstream over a valid/ready handshake.
- Runs one frame of N pixels per `start` pulse, all in the `sclk` domain.

---
 rtl/sreg_rx_pkg.sv | 17 +
 rtl/sreg_readout_rx_if.sv | 32 +++
 rtl/sreg_lane_deser.sv | 36 +++
 rtl/sreg_readout_rx.sv | 192 +++++++++++++++++++
 tb/tb_sreg_readout_rx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sreg_rx_pkg.sv
// sreg_rx_pkg
//   Shared definitions for the 2-lane pixel shift-register readout receiver:
//   default pixel/counter widths, lane length and the controller state type.
package sreg_rx_pkg;

    localparam int PIX_W_DEF = 42;               // pixel word width (even)
    localparam int CNT_W_DEF = 16;               // pixel count / index width
    localparam int LANE_LEN  = PIX_W_DEF / 2;    // bits carried per lane

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sreg_readout_rx_if.sv
// sreg_readout_rx_if
//   Pixel output bus of the readout receiver (valid/ready handshake).
//   pixel_data  : reassembled pixel word
//   pixel_valid : pixel_data holds an unconsumed word
//   pixel_ready : downstream accepts the word
//   pixel_idx   : 0-based index of the word within the frame
//   master = receiver side, slave = downstream consumer.
interface sreg_readout_rx_if
    import sreg_rx_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [PIX_W-1:0] pixel_data;
    logic             pixel_valid;
    logic             pixel_ready;
    logic [CNT_W-1:0] pixel_idx;

    modport master (
        output pixel_data,
        output pixel_valid,
        output pixel_idx,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  pixel_idx,
        output pixel_ready
    );
endinterface

// File: rtl/sreg_lane_deser.sv
// sreg_lane_deser
//   Single-lane MSB-first accumulator. Only the LANE_LEN-1 oldest bits are
//   stored; word_next presents the full lane word including the bit being
//   captured this cycle, so the parent can latch a complete word on the
//   final capture edge without an extra cycle.
//   Ports: sclk, rst (async, active-high), clr (sync clear), cap_en (shift in
//   din), din (lane serial bit), word_next (stored bits & din).
module sreg_lane_deser
    import sreg_rx_pkg::*;
#(
    parameter int LANE_LEN_P = LANE_LEN
)
(
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  cap_en,
    input  logic                  din,
    output logic [LANE_LEN_P-1:0] word_next
);

    logic [LANE_LEN_P-2:0] acc_reg;

    assign word_next = {acc_reg, din};

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (cap_en) begin
            acc_reg <= word_next[LANE_LEN_P-2:0];
        end
    end

endmodule

// File: rtl/sreg_readout_rx.sv
// sreg_readout_rx
//   Readout controller and deserializer for the 2-lane pixel shift register.
//   Drives shift (0 = load, 1 = shift), captures the register's registered
//   2-bit output one edge later, rebuilds each PIX_W-bit word and hands it
//   downstream on pix_if. One frame of num_pixels words per start pulse.
//   Ports: sclk, rst (async, active-high), start, abort, num_pixels,
//   sreg_out (lane0 = bit0 -> word MSB half, lane1 = bit1 -> LSB half),
//   pixel_ref, shift, pix_adv, pix_if (master), busy, done, mismatch.
//   Optional build macro SREG_READOUT_CHECK_EN: latch pixel_ref when a pixel
//   starts shifting and flag (sticky until rst or start) any word that
//   differs from it. Without the macro mismatch is constant 0.
module sreg_readout_rx
    import sreg_rx_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic               sclk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_pixels,
    input  logic [1:0]         sreg_out,
    input  logic [PIX_W-1:0]   pixel_ref,
    output logic               shift,
    output logic               pix_adv,
    sreg_readout_rx_if.master  pix_if,
    output logic               busy,
    output logic               done,
    output logic               mismatch
);

    localparam int L  = PIX_W / 2;
    localparam int BW = $clog2(L);

    state_t           state_reg, state_next;
    logic [BW-1:0]    bit_cnt_reg, cap_cnt_reg;
    logic [CNT_W-1:0] num_reg, pix_cnt_reg, cap_idx_reg;
    logic             shift_d_reg, pix_adv_reg, busy_reg, done_reg;
    logic [PIX_W-1:0] data_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] idx_reg;

    logic             start_go, abort_hit, load_exit, last_pix, last_accept;
    logic             cap_en, word_done;
    logic [L-1:0]     lane_word [2];
    logic [PIX_W-1:0] word_next;

    assign start_go    = (state_reg == ST_IDLE) && start;
    assign abort_hit   = (state_reg != ST_IDLE) && abort;
    assign last_pix    = (pix_cnt_reg == num_reg - CNT_W'(1));
    assign last_accept = (state_reg == ST_DRAIN) && valid_reg && pix_if.pixel_ready
                         && (idx_reg == num_reg - CNT_W'(1));
    // Output data lags shift by one edge, so capture follows the delayed shift.
    assign cap_en      = shift_d_reg && !abort_hit;
    assign word_done   = cap_en && (cap_cnt_reg == BW'(L - 1));
    assign load_exit   = (state_reg == ST_LOAD) && (state_next == ST_SHIFT);
    assign word_next   = {lane_word[0], lane_word[1]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            sreg_lane_deser #(.LANE_LEN_P(L)) u_lane (
                .sclk      (sclk),
                .rst       (rst),
                .clr       (abort_hit),
                .cap_en    (cap_en),
                .din       (sreg_out[gi]),
                .word_next (lane_word[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start && num_pixels != '0) state_next = ST_LOAD;
            // Leave LOAD only once the previous pixel's capture has finished
            // and its word is gone (or leaves this edge): no overwrite possible.
            ST_LOAD:  if (!shift_d_reg && (!valid_reg || pix_if.pixel_ready))
                          state_next = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_reg == BW'(L - 1))
                          state_next = last_pix ? ST_DRAIN : ST_LOAD;
            ST_DRAIN: if (last_accept) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_hit) state_next = ST_IDLE;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            cap_cnt_reg <= '0;
            num_reg     <= '0;
            pix_cnt_reg <= '0;
            cap_idx_reg <= '0;
            shift_d_reg <= 1'b0;
            pix_adv_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            idx_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            shift_d_reg <= shift && !abort_hit;
            pix_adv_reg <= load_exit;
            done_reg    <= 1'b0;

            if (start_go) begin
                num_reg     <= num_pixels;
                pix_cnt_reg <= '0;
                cap_idx_reg <= '0;
                bit_cnt_reg <= '0;
                cap_cnt_reg <= '0;
                if (num_pixels == '0) done_reg <= 1'b1;
                else                  busy_reg <= 1'b1;
            end

            if (state_reg == ST_SHIFT) begin
                if (bit_cnt_reg == BW'(L - 1)) begin
                    bit_cnt_reg <= '0;
                    if (!last_pix) pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
            end

            // A word written this edge takes priority over the ready clear.
            if (pix_if.pixel_ready) valid_reg <= 1'b0;
            if (cap_en) begin
                if (word_done) begin
                    data_reg    <= word_next;
                    valid_reg   <= 1'b1;
                    idx_reg     <= cap_idx_reg;
                    cap_idx_reg <= cap_idx_reg + CNT_W'(1);
                    cap_cnt_reg <= '0;
                end else begin
                    cap_cnt_reg <= cap_cnt_reg + BW'(1);
                end
            end

            if (last_accept) begin
                done_reg <= 1'b1;
                busy_reg <= 1'b0;
            end

            if (abort_hit) begin
                busy_reg    <= 1'b0;
                done_reg    <= 1'b0;
                valid_reg   <= 1'b0;
                bit_cnt_reg <= '0;
                cap_cnt_reg <= '0;
            end
        end
    end

    assign shift              = (state_reg == ST_SHIFT);
    assign pix_adv            = pix_adv_reg;
    assign busy               = busy_reg;
    assign done               = done_reg;
    assign pix_if.pixel_data  = data_reg;
    assign pix_if.pixel_valid = valid_reg;
    assign pix_if.pixel_idx   = idx_reg;

`ifdef SREG_READOUT_CHECK_EN
    logic [PIX_W-1:0] ref_q_reg;
    logic             mismatch_reg;

    // ref_q is taken on the same edge the register last loads pixel_ref.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            ref_q_reg    <= '0;
            mismatch_reg <= 1'b0;
        end else begin
            if (load_exit) ref_q_reg <= pixel_ref;
            if (start_go)
                mismatch_reg <= 1'b0;
            else if (word_done && (word_next != ref_q_reg))
                mismatch_reg <= 1'b1;
        end
    end

    assign mismatch = mismatch_reg;
`else
    logic ref_unused;
    assign ref_unused = ^pixel_ref;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_sreg_readout_rx.sv
`timescale 1ns/1ps
module tb_sreg_readout_rx;

    localparam int PIX_W = 42;
    localparam int CNT_W = 16;
    localparam int L     = PIX_W / 2;

    logic             sclk = 1'b0;
    logic             rst  = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] num_pixels = '0;
    logic [1:0]       sreg_out;
    logic [PIX_W-1:0] pixel_ref;
    logic             shift, pix_adv, busy, done, mismatch;

    sreg_readout_rx_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) pif ();

    sreg_readout_rx #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_pixels (num_pixels),
        .sreg_out   (sreg_out),
        .pixel_ref  (pixel_ref),
        .shift      (shift),
        .pix_adv    (pix_adv),
        .pix_if     (pif),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch)
    );

    always #5 sclk = ~sclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    // ---------------- pixel source + 2-lane shift register model ----------
    logic [PIX_W-1:0] src_base = '0;
    bit               src_inc  = 1'b0;
    bit               lane1_zero = 1'b0;
    int               adv_cnt  = 0;
    int               adv_base = 0;
    logic [L-1:0]     sr0, sr1;
    logic [1:0]       so;

    assign pixel_ref = src_inc ? src_base + PIX_W'(adv_cnt - adv_base) : src_base;
    assign sreg_out  = so;

    always @(posedge sclk) if (pix_adv) adv_cnt <= adv_cnt + 1;

    always @(posedge sclk or posedge rst) begin
        if (rst) begin
            sr0 <= '0; sr1 <= '0; so <= '0;
        end else if (shift) begin
            so  <= {(lane1_zero ? 1'b0 : sr1[L-1]), sr0[L-1]};
            sr0 <= {sr0[L-2:0], 1'b0};
            sr1 <= {sr1[L-2:0], 1'b0};
        end else begin
            sr0 <= pixel_ref[PIX_W-1:L];
            sr1 <= pixel_ref[L-1:0];
        end
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct {
        logic [PIX_W-1:0] data;
        logic [CNT_W-1:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   acc_q[$];
    int   last_acc_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rise_cyc = 0;
    bit   prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [PIX_W-1:0] d, input logic [CNT_W-1:0] i);
        exp_t e;
        e.data = d;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic set_src(input logic [PIX_W-1:0] base, input bit inc);
        src_base = base;
        src_inc  = inc;
        adv_base = adv_cnt;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = done_cnt;
        for (int i = 0; i < budget && done_cnt == n; i++) begin
            @(negedge sclk); #1;
        end
        chk(tag, done_cnt - n, 1);
    endtask

    // Monitor: handshake seen mid-cycle completes on the next rising edge.
    always @(negedge sclk) begin
        if (pif.pixel_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = pif.pixel_valid;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pif.pixel_valid && pif.pixel_ready && !rst) begin
            acc_q.push_back(cyc);
            last_acc_cyc = cyc;
            $display("word idx=%0d data=%h cyc=%0d", pif.pixel_idx, pif.pixel_data, cyc);
            if (sb.size() == 0) begin
                chk("sb_extra_word", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("word_data", pif.pixel_data, mon_e.data);
                chk("word_idx", pif.pixel_idx, mon_e.idx);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int bad;
        pif.pixel_ready = 1'b0;

        // ---- reset values ----
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_shift", shift, 0);
        chk("rst_pix_adv", pix_adv, 0);
        chk("rst_valid", pif.pixel_valid, 0);
        chk("rst_data", pif.pixel_data, 0);
        chk("rst_idx", pif.pixel_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mismatch", mismatch, 0);
        @(posedge sclk); #2 rst = 1'b0;

        // ---- A: async reset in the middle of SHIFT ----
        @(posedge sclk); #2;
        set_src(42'h155_5555_AAAA, 1'b0);
        pif.pixel_ready = 1'b1; num_pixels = 16'd2; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        @(negedge sclk);
        chk("a_busy", busy, 1);
        repeat (11) @(posedge sclk);
        #3;
        chk("a_shift_before_rst", shift, 1);
        rst = 1'b1;
        #1;
        chk("a_rst_busy", busy, 0);
        chk("a_rst_shift", shift, 0);
        chk("a_rst_valid", pif.pixel_valid, 0);
        @(posedge sclk); #2 rst = 1'b0;

        // ---- B: single pixel, latency and done timing ----
        @(posedge sclk); #2;
        set_src(42'h2AA_AAAA_5555, 1'b0);
        push(42'h2AA_AAAA_5555, 16'd0);
        num_pixels = 16'd1; start = 1'b1; s = cyc;
        @(posedge sclk); #2 start = 1'b0;
        wait_done("b_done", 100);
        chk("b_latency", rise_cyc - s, 24);
        chk("b_done_lat", done_cyc - last_acc_cyc, 1);
        chk("b_busy_end", busy, 0);

        // ---- C: four pixels, incrementing source, start while busy ----
        acc_q.delete();
        @(posedge sclk); #2;
        set_src(42'h1, 1'b1);
        for (int k = 0; k < 4; k++) push(PIX_W'(k + 1), CNT_W'(k));
        num_pixels = 16'd4; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        repeat (30) @(posedge sclk);
        #2 start = 1'b1; num_pixels = 16'd9;
        @(posedge sclk); #2 start = 1'b0;
        wait_done("c_done", 200);
        chk("c_words", acc_q.size(), 4);
        for (int k = 0; k < 3; k++) chk("c_gap", acc_q[k+1] - acc_q[k], 23);
        repeat (30) @(negedge sclk);
        chk("c_idle_after", busy, 0);

        // ---- D: backpressure after word 0 ----
        @(posedge sclk); #2;
        set_src(42'h10, 1'b1);
        push(42'h10, 16'd0); push(42'h11, 16'd1); push(42'h12, 16'd2);
        pif.pixel_ready = 1'b0; num_pixels = 16'd3; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        for (int i = 0; i < 60 && !pif.pixel_valid; i++) @(negedge sclk);
        chk("d_valid_seen", pif.pixel_valid, 1);
        bad = 0;
        repeat (50) begin
            @(negedge sclk);
            if (!(pif.pixel_valid && pif.pixel_data == 42'h10 && pif.pixel_idx == 16'd0
                  && !shift && !pix_adv)) bad++;
        end
        chk("d_hold", bad, 0);
        @(posedge sclk); #2 pif.pixel_ready = 1'b1;
        wait_done("d_done", 200);
        chk("d_sb_empty", sb.size(), 0);

        // ---- E: abort at bit_cnt=5 of pixel 2 ----
        @(posedge sclk); #2;
        set_src(42'h20, 1'b1);
        push(42'h20, 16'd0); push(42'h21, 16'd1);
        num_pixels = 16'd4; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        repeat (52) @(posedge sclk);
        #2;
        chk("e_shift_before_abort", shift, 1);
        abort = 1'b1;
        @(posedge sclk); #2 abort = 1'b0;
        @(negedge sclk);
        chk("e_busy", busy, 0);
        chk("e_valid", pif.pixel_valid, 0);
        chk("e_shift", shift, 0);
        s = done_cnt;
        repeat (40) @(negedge sclk);
        #1;
        chk("e_no_done", done_cnt - s, 0);
        chk("e_sb_empty", sb.size(), 0);

        // ---- F: num_pixels == 0 ----
        @(posedge sclk); #2;
        num_pixels = 16'd0; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        @(negedge sclk);
        chk("f_done", done, 1);
        chk("f_busy", busy, 0);

        // ---- G: start and abort together in IDLE, start wins ----
        @(posedge sclk); #2;
        set_src(42'h3_0F0F_0F0F, 1'b0);
        push(42'h3_0F0F_0F0F, 16'd0);
        num_pixels = 16'd1; start = 1'b1; abort = 1'b1;
        @(posedge sclk); #2 start = 1'b0; abort = 1'b0;
        @(negedge sclk);
        chk("g_busy", busy, 1);
        wait_done("g_done", 100);

        // ---- H: lane1 stuck low against pixel_ref all ones ----
        @(posedge sclk); #2;
        set_src(42'h3FF_FFFF_FFFF, 1'b0);
        lane1_zero = 1'b1;
        push(42'h3FF_FFE0_0000, 16'd0);
        num_pixels = 16'd1; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        wait_done("h_done", 100);
        lane1_zero = 1'b0;
`ifdef SREG_READOUT_CHECK_EN
        chk("h_mismatch_set", mismatch, 1);
        repeat (10) @(negedge sclk);
        chk("h_mismatch_sticky", mismatch, 1);
`else
        chk("h_mismatch_off", mismatch, 0);
        repeat (10) @(negedge sclk);
        chk("h_mismatch_off_later", mismatch, 0);
`endif
        @(posedge sclk); #2;
        set_src(42'h5, 1'b0);
        push(42'h5, 16'd0);
        num_pixels = 16'd1; start = 1'b1;
        @(posedge sclk); #2 start = 1'b0;
        @(negedge sclk); #1;
        chk("h_mismatch_cleared", mismatch, 0);
        wait_done("h2_done", 100);
        chk("h_mismatch_clean", mismatch, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
